// File: rtl/pipeline_pkg.sv
// Shared types for the instruction-fetch stage.
//   NOP_INST      : addi x0,x0,0, presented to decode when no instruction is valid
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : one fetched instruction with its PC (fetch-buffer payload)
package pipeline_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch buffer of {pc,inst} entries.
//   clk, reset      : clock, synchronous active-high reset
//   clear           : synchronous flush of all entries (redirect)
//   push, push_data : write one entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head            : oldest entry, valid when !empty
//   count/full/empty: occupancy
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pipeline_ifr_stage.sv
// Instruction-fetch producer feeding the decode stage.
//   clk, reset                 : clock, synchronous active-high reset
//   stall, flush               : hold / bubble the IF/ID output register
//   redirect_en, redirect_pc   : restart fetch at a new (word-aligned) PC
//   imem_req/addr/gnt          : fetch request handshake (one outstanding max)
//   imem_rvalid/rdata          : in-order instruction response
//   instruction_IF/pc_IFR/valid_IF : IF/ID output register
module pipeline_ifr_stage
  import pipeline_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [63:0] pc_IFR,
  output logic        valid_IF
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     state;
  logic [63:0]      fetch_pc;
  logic [63:0]      req_pc;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full;
  logic             buf_empty;
  fetch_entry_t     buf_head;
  fetch_entry_t     rsp_entry;
  logic             outstanding;
  logic             rsp_ok;
  logic             bypass;
  logic             push;
  logic             pop;

  assign outstanding = (state != S_REQ);
  assign imem_addr   = fetch_pc;
  // Never request more than the buffer could absorb if decode stays stalled.
  assign imem_req    = !reset && !redirect_en && (state == S_REQ) &&
                       ((buf_count + CNT_W'(outstanding)) < CNT_W'(BUF_DEPTH));

  // A live response either goes straight to the output register or is buffered.
  assign rsp_ok    = (state == S_WAIT) && imem_rvalid && !redirect_en;
  assign bypass    = rsp_ok && buf_empty && !flush && !stall;
  assign push      = rsp_ok && !bypass;
  assign pop       = !redirect_en && !flush && !stall && !buf_empty;
  assign rsp_entry = '{pc: req_pc, inst: imem_rdata};

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_en),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Fetch FSM, fetch PC and IF/ID output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_REQ;
      fetch_pc       <= RESET_PC;
      req_pc         <= '0;
      instruction_IF <= NOP_INST;
      pc_IFR         <= '0;
      valid_IF       <= 1'b0;
    end else if (redirect_en) begin
      fetch_pc       <= redirect_pc & ~64'h3;
      instruction_IF <= NOP_INST;
      pc_IFR         <= '0;
      valid_IF       <= 1'b0;
      // A response landing now is the stale one; otherwise wait it out.
      if (imem_rvalid && outstanding)       state <= S_REQ;
      else if (outstanding || imem_gnt)     state <= S_DISCARD;
      else                                  state <= S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 64'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT:    if (imem_rvalid) state <= S_REQ;
        S_DISCARD: if (imem_rvalid) state <= S_REQ;
        default:   state <= S_REQ;
      endcase

      if (flush) begin
        instruction_IF <= NOP_INST;
        pc_IFR         <= '0;
        valid_IF       <= 1'b0;
      end else if (!stall) begin
        if (!buf_empty) begin
          instruction_IF <= buf_head.inst;
          pc_IFR         <= buf_head.pc;
          valid_IF       <= 1'b1;
        end else if (bypass) begin
          instruction_IF <= imem_rdata;
          pc_IFR         <= req_pc;
          valid_IF       <= 1'b1;
        end else begin
          instruction_IF <= NOP_INST;
          valid_IF       <= 1'b0;
        end
      end
    end
  end

  // Protocol checks for simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && buf_full))
        else $error("pipeline_ifr_stage: fetch buffer overflow");
      assert (!(imem_rvalid && state == S_REQ))
        else $error("pipeline_ifr_stage: rvalid with no request outstanding");
    end
  end

endmodule
